sync_down_counter: RTL and testbench

// - Synchronous, loadable, WIDTH-bit down counter (count-down timer).
// - Complements the existing ripple up-counter: all state is clocked from one clk, no derived clocks.
// - Loaded with a start value, decrements on enable, and flags terminal count with a one-cycle pulse on reaching zero.
// - Used as a programmable delay/timeout source next to the up-counter.
//

---
 rtl/sync_counter_pkg.sv | 23 ++
 rtl/sync_down_counter.sv | 111 +++++++++++
 tb/tb_sync_down_counter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_counter_pkg.sv
// ============================================================================
// Module      : sync_counter_pkg
// Description : Shared types and limits for the synchronous down counter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sync_counter_pkg;

  // Counter control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  // Widest counter this block is intended to be built with
  localparam int MAX_WIDTH = 16;

endpackage : sync_counter_pkg

`default_nettype wire

// File: rtl/sync_down_counter.sv
// ============================================================================
// Module      : sync_down_counter
// Description : Synchronous, loadable WIDTH-bit down counter. A non-zero load
//               starts a count; reaching zero holds DONE for one cycle and
//               pulses tc. Priority per cycle: clear > load > decrement.
//               Optional feature macro: SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
//               (DONE restarts the count from the last loaded value).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_down_counter
  import sync_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             zero,
  output logic             tc
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  // Next-state, next-count and reload-value selection
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      // A zero start value has nothing to count, so no tc is produced
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (en) begin
            // Q<=1 folds into the terminal step so the count can never wrap
            if (count_q > C_ONE) begin
              count_d = count_q - C_ONE;
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end
        end
        DONE: begin
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            state_d = RUN;
            count_d = reload_q;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State, count and reload registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

`ifndef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
  // The reload value is kept up to date but only consumed by auto-reload
  logic unused_reload;
  assign unused_reload = ^reload_q;
`endif

  assign Q    = count_q;
  assign busy = (state_q != IDLE);
  assign zero = (count_q == '0);
  assign tc   = (state_q == DONE);

endmodule : sync_down_counter

`default_nettype wire

// File: tb/tb_sync_down_counter.sv
// ============================================================================
// Module      : tb_sync_down_counter
// Description : Directed self-checking bench for sync_down_counter (WIDTH=4).
//               Expectations follow SYNC_DOWN_COUNTER_AUTO_RELOAD_EN when set.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sync_down_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset_n;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             zero;
  logic             tc;

  int vectors;
  int miscompares;

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .Q        (Q),
    .busy     (busy),
    .zero     (zero),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; sample and drive 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {Q, busy, zero, tc} against hand-computed values
  task automatic check(input string tag, input logic [WIDTH-1:0] q_exp,
                       input logic busy_exp, input logic zero_exp,
                       input logic tc_exp);
    logic [WIDTH+2:0] obs;
    logic [WIDTH+2:0] exp;
    obs = {Q, busy, zero, tc};
    exp = {q_exp, busy_exp, zero_exp, tc_exp};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed {Q,busy,zero,tc}=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n  = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;

    // Reset state before any clock edge
    #3;
    check("reset_initial", 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_after_reset", 4'd0, 1'b0, 1'b1, 1'b0);

    // Load 3 with en held high: 3,2,1,0
    load = 1'b1; load_val = 4'd3; en = 1'b1;
    tick();
    load = 1'b0;
    check("l3_q3", 4'd3, 1'b1, 1'b0, 1'b0);
    tick(); check("l3_q2", 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); check("l3_q1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); check("l3_done", 4'd0, 1'b1, 1'b1, 1'b1);
    tick();
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    check("l3_reload", 4'd3, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("l3_clear", 4'd0, 1'b0, 1'b1, 1'b0);
`else
    check("l3_idle", 4'd0, 1'b0, 1'b1, 1'b0);
`endif

    // Load 4 with en toggling: decrements only on enabled cycles
    load = 1'b1; load_val = 4'd4; en = 1'b0;
    tick();
    load = 1'b0;
    check("l4_q4", 4'd4, 1'b1, 1'b0, 1'b0);
    en = 1'b1; tick(); check("l4_en1_q3", 4'd3, 1'b1, 1'b0, 1'b0);
    en = 1'b0; tick(); check("l4_en0_q3", 4'd3, 1'b1, 1'b0, 1'b0);
    en = 1'b1; tick(); check("l4_en1_q2", 4'd2, 1'b1, 1'b0, 1'b0);
    en = 1'b0; tick(); check("l4_en0_q2", 4'd2, 1'b1, 1'b0, 1'b0);
    en = 1'b1; tick(); check("l4_en1_q1", 4'd1, 1'b1, 1'b0, 1'b0);
    en = 1'b0; tick(); check("l4_en0_q1", 4'd1, 1'b1, 1'b0, 1'b0);
    en = 1'b1; tick(); check("l4_done", 4'd0, 1'b1, 1'b1, 1'b1);
    en = 1'b0; tick();
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    check("l4_reload", 4'd4, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("l4_clear", 4'd0, 1'b0, 1'b1, 1'b0);
`else
    check("l4_idle", 4'd0, 1'b0, 1'b1, 1'b0);
`endif

    // Clear beats load while running
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    check("prio_run_q5", 4'd5, 1'b1, 1'b0, 1'b0);
    load = 1'b1; clear = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; clear = 1'b0;
    check("prio_clear_over_load", 4'd0, 1'b0, 1'b1, 1'b0);

    // Load during DONE restarts the count
    load = 1'b1; load_val = 4'd1; en = 1'b1;
    tick();
    load = 1'b0;
    check("prio_l1_q1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    check("prio_l1_done", 4'd0, 1'b1, 1'b1, 1'b1);
    load = 1'b1; load_val = 4'd6;
    tick();
    load = 1'b0;
    check("prio_load_in_done", 4'd6, 1'b1, 1'b0, 1'b0);
    tick();
    check("prio_after_load_q5", 4'd5, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-count (Q=5, RUN), no clock edge in between
    reset_n = 1'b0;
    #2;
    check("async_reset_run", 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("after_reset_run", 4'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in DONE drops the pending tc
    load = 1'b1; load_val = 4'd1; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("pre_reset_done", 4'd0, 1'b1, 1'b1, 1'b1);
    reset_n = 1'b0;
    #2;
    check("async_reset_done", 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // Load of zero from RUN: straight to IDLE, no tc
    load = 1'b1; load_val = 4'd7; en = 1'b0;
    tick();
    check("l7_run", 4'd7, 1'b1, 1'b0, 1'b0);
    load_val = 4'd0;
    tick();
    load = 1'b0;
    check("load_zero", 4'd0, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    tick();
    check("load_zero_en_ignored", 4'd0, 1'b0, 1'b1, 1'b0);

    // Full-scale load of 15: tc on the 15th enabled edge
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    check("l15_q15", 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("l15_step%0d", i), 4'(15 - i), 1'b1, (i == 15), (i == 15));
    end
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    tick();
    check("l15_reload", 4'd15, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("l15_clear", 4'd0, 1'b0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("l15_no_wrap%0d", i), 4'd0, 1'b0, 1'b1, 1'b0);
    end
`endif

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    // Auto-reload of 2: 2,1,0 repeating, tc on every third cycle
    load = 1'b1; load_val = 4'd2; en = 1'b1;
    tick();
    load = 1'b0;
    check("ar_q2_first", 4'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      case (i % 3)
        1:       check($sformatf("ar_step%0d", i), 4'd1, 1'b1, 1'b0, 1'b0);
        2:       check($sformatf("ar_step%0d", i), 4'd0, 1'b1, 1'b1, 1'b1);
        default: check($sformatf("ar_step%0d", i), 4'd2, 1'b1, 1'b0, 1'b0);
      endcase
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ar_clear", 4'd0, 1'b0, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sync_down_counter

`default_nettype wire
